// File: rtl/wb_interconnect_pkg.sv
// Shared types and constants for the registered round-robin Wishbone crossbar.
// Holds the arbiter state encoding, the idle grant value and the index-width helper.
package wb_interconnect_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Value of every grant bit while a target has no owner.
    localparam logic NO_GRANT = 1'b0;

    // Bits needed to hold an index into n items; never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MIN_ID_WIDTH = 1;

endpackage

// File: rtl/wb_interconnect_rr_arb.sv
// Per-target round-robin arbiter with registered one-hot grant.
// The grant is locked to its owner until the owner drops cyc or a forced release arrives.
module wb_interconnect_rr_arb
    import wb_interconnect_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             owner_cyc,
    input  logic             force_release,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    localparam int ID_W = (id_width(N_REQ) > MIN_ID_WIDTH) ? id_width(N_REQ) : MIN_ID_WIDTH;

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  idx;
    logic             found;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        idx     = '0;
        found   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // Search starts just after the last winner, so the last winner is tried last.
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = ID_W'((int'(ptr_q) + k) % N_REQ);
                    if (!found && req[idx]) begin
                        found      = 1'b1;
                        gnt_d      = {N_REQ{NO_GRANT}};
                        gnt_d[idx] = 1'b1;
                        ptr_d      = idx;
                        state_d    = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                if (!owner_cyc || force_release) begin
                    gnt_d   = {N_REQ{NO_GRANT}};
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                gnt_d   = {N_REQ{NO_GRANT}};
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= {N_REQ{NO_GRANT}};
            ptr_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == ARB_BUSY);

endmodule

// File: rtl/wb_interconnect_rr_nxn.sv
// NxN Wishbone classic crossbar: base/mask decode, per-target round-robin lock, unmapped-address error responder.
// Optional per-target watchdog enabled by defining WB_IC_TIMEOUT_EN.
module wb_interconnect_rr_nxn
    import wb_interconnect_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 2,
    parameter int N_TARGETS      = 2,
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR      = {32'h2000_0000, 32'h1000_0000},
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]   adr,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   dat_w,
    input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0] sel,
    input  logic [N_INITIATORS-1:0]                 cyc,
    input  logic [N_INITIATORS-1:0]                 stb,
    input  logic [N_INITIATORS-1:0]                 we,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   dat_r,
    output logic [N_INITIATORS-1:0]                 ack,
    output logic [N_INITIATORS-1:0]                 err,
    output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]      tadr,
    output logic [N_TARGETS*WB_DATA_WIDTH-1:0]      tdat_w,
    output logic [N_TARGETS*WB_DATA_WIDTH/8-1:0]    tsel,
    output logic [N_TARGETS-1:0]                    tcyc,
    output logic [N_TARGETS-1:0]                    tstb,
    output logic [N_TARGETS-1:0]                    twe,
    input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]      tdat_r,
    input  logic [N_TARGETS-1:0]                    tack,
    input  logic [N_TARGETS-1:0]                    terr
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int NI = N_INITIATORS;
    localparam int NT = N_TARGETS;

    logic [NI-1:0][NT-1:0] first_hit;
    logic [NI-1:0]         mapped;
    logic [NI-1:0]         unmapped_req;
    logic [NT-1:0][NI-1:0] req_ti;
    logic [NT-1:0][NI-1:0] gnt;
    logic [NT-1:0]         busy;
    logic [NT-1:0]         owner_cyc;
    logic [NT-1:0]         owner_stb;
    logic [NT-1:0]         timeout_hit;
    logic [NI-1:0]         resp_found;
    logic [NI-1:0]         tgt_err;
    logic [NI-1:0]         err_resp_q, err_resp_d;

    // Lowest-numbered matching target wins when windows overlap.
    always_comb begin
        first_hit    = '0;
        mapped       = '0;
        unmapped_req = '0;
        req_ti       = '0;
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < NT; t++) begin
                if (!mapped[i] &&
                    ((adr[i*AW +: AW] & T_ADR_MASK[t*AW +: AW]) == T_ADR[t*AW +: AW])) begin
                    first_hit[i][t] = 1'b1;
                    mapped[i]       = 1'b1;
                end
                req_ti[t][i] = cyc[i] & stb[i] & first_hit[i][t];
            end
            unmapped_req[i] = cyc[i] & stb[i] & ~mapped[i];
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_arb
        wb_interconnect_rr_arb #(
            .N_REQ(NI)
        ) u_arb (
            .clock        (clock),
            .reset_n      (reset_n),
            .req          (req_ti[t]),
            .owner_cyc    (owner_cyc[t]),
            .force_release(timeout_hit[t]),
            .gnt          (gnt[t]),
            .busy         (busy[t])
        );
    end

    // Forward path: only the owner's fields reach a target; everything else reads as zero.
    always_comb begin
        owner_cyc = '0;
        owner_stb = '0;
        tadr      = '0;
        tdat_w    = '0;
        tsel      = '0;
        twe       = '0;
        tcyc      = '0;
        tstb      = '0;
        for (int t = 0; t < NT; t++) begin
            owner_cyc[t] = |(gnt[t] & cyc);
            owner_stb[t] = |(gnt[t] & stb);
            for (int i = 0; i < NI; i++) begin
                if (gnt[t][i]) begin
                    tadr[t*AW +: AW]   = adr[i*AW +: AW];
                    tdat_w[t*DW +: DW] = dat_w[i*DW +: DW];
                    tsel[t*SW +: SW]   = sel[i*SW +: SW];
                    twe[t]             = we[i];
                end
            end
            tcyc[t] = busy[t] & owner_cyc[t] & ~timeout_hit[t];
            tstb[t] = busy[t] & owner_stb[t] & ~timeout_hit[t];
        end
    end

    // Response path: err beats ack when a target raises both.
    always_comb begin
        dat_r      = '0;
        ack        = '0;
        tgt_err    = '0;
        resp_found = '0;
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < NT; t++) begin
                if (gnt[t][i] && !resp_found[i]) begin
                    resp_found[i]     = 1'b1;
                    dat_r[i*DW +: DW] = tdat_r[t*DW +: DW];
                    ack[i]            = tack[t] & ~terr[t] & ~timeout_hit[t];
                    tgt_err[i]        = terr[t] | timeout_hit[t];
                end
            end
        end
    end

    // A held unmapped strobe produces pulse, gap, pulse, ...
    always_comb begin
        err_resp_d = unmapped_req & ~err_resp_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_resp_q <= '0;
        end else begin
            err_resp_q <= err_resp_d;
        end
    end

    assign err = tgt_err | err_resp_q;

`ifdef WB_IC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NT-1:0][TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        timeout_hit = '0;
        to_cnt_d    = to_cnt_q;
        for (int t = 0; t < NT; t++) begin
            timeout_hit[t] = busy[t] && (to_cnt_q[t] == TO_W'(TIMEOUT_CYCLES - 1));
            if (!busy[t] || tack[t] || terr[t] || timeout_hit[t]) begin
                to_cnt_d[t] = '0;
            end else if (owner_cyc[t] && owner_stb[t]) begin
                to_cnt_d[t] = to_cnt_q[t] + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = '0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_interconnect_rr_nxn.sv
// Directed bench for the 2x2 round-robin crossbar: vector table plus hand sequences for
// round-robin order, asynchronous reset and (with WB_IC_TIMEOUT_EN) the watchdog.
module tb_wb_interconnect_rr_nxn;

    logic        clock;
    logic        reset_n;
    logic [63:0] adr;
    logic [63:0] dat_w;
    logic [7:0]  sel;
    logic [1:0]  cyc, stb, we;
    logic [63:0] dat_r;
    logic [1:0]  ack, err;
    logic [63:0] tadr;
    logic [63:0] tdat_w;
    logic [7:0]  tsel;
    logic [1:0]  tcyc, tstb, twe;
    logic [63:0] tdat_r;
    logic [1:0]  tack, terr;

    int n_checks = 0;
    int n_errors = 0;

    wb_interconnect_rr_nxn #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .adr    (adr),
        .dat_w  (dat_w),
        .sel    (sel),
        .cyc    (cyc),
        .stb    (stb),
        .we     (we),
        .dat_r  (dat_r),
        .ack    (ack),
        .err    (err),
        .tadr   (tadr),
        .tdat_w (tdat_w),
        .tsel   (tsel),
        .tcyc   (tcyc),
        .tstb   (tstb),
        .twe    (twe),
        .tdat_r (tdat_r),
        .tack   (tack),
        .terr   (terr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  cyc, stb;
        logic [31:0] adr0, adr1;
        logic [1:0]  tack, terr;
        logic [31:0] tdat0, tdat1;
        logic [1:0]  e_tcyc, e_tstb, e_ack, e_err;
        logic [31:0] e_dat0, e_dat1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [1:0] c, input logic [1:0] s,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] ta, input logic [1:0] te,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] ec, input logic [1:0] es,
                       input logic [1:0] ea, input logic [1:0] ee,
                       input logic [31:0] ed0, input logic [31:0] ed1);
        vec_t v;
        v.name = name; v.cyc = c; v.stb = s; v.adr0 = a0; v.adr1 = a1;
        v.tack = ta; v.terr = te; v.tdat0 = d0; v.tdat1 = d1;
        v.e_tcyc = ec; v.e_tstb = es; v.e_ack = ea; v.e_err = ee;
        v.e_dat0 = ed0; v.e_dat1 = ed1;
        vecs.push_back(v);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic [1:0] c, input logic [1:0] s, input logic [1:0] ta);
        @(negedge clock);
        cyc  = c;
        stb  = s;
        tack = ta;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        adr     = '0;
        dat_w   = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        sel     = 8'hFF;
        cyc     = '0;
        stb     = '0;
        we      = 2'b01;
        tdat_r  = '0;
        tack    = '0;
        terr    = '0;

        //          name         cyc    stb    adr0           adr1           tack   terr   tdat0          tdat1          tcyc   tstb   ack    err    dat_r0         dat_r1
        add("idle0",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("t1_req",    2'b01, 2'b01, 32'h1000_0004, 32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("t1_wait",   2'b01, 2'b01, 32'h1000_0004, 32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b01, 2'b01, 2'b00, 2'b00, 32'h0,         32'h0);
        add("t1_ack",    2'b01, 2'b01, 32'h1000_0004, 32'h0,         2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0,         2'b01, 2'b01, 2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0);
        add("t1_drop",   2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("idle1",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("t3_req",    2'b11, 2'b11, 32'h1000_0000, 32'h2000_0010, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("t3_ack0",   2'b11, 2'b11, 32'h1000_0000, 32'h2000_0010, 2'b01, 2'b00, 32'h1111_1111, 32'h2222_2222, 2'b11, 2'b11, 2'b01, 2'b00, 32'h1111_1111, 32'h2222_2222);
        add("t3_ack1",   2'b11, 2'b11, 32'h1000_0000, 32'h2000_0010, 2'b10, 2'b00, 32'hAAAA_0000, 32'h3333_3333, 2'b11, 2'b11, 2'b10, 2'b00, 32'hAAAA_0000, 32'h3333_3333);
        add("t3_drop",   2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("idle2",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("ae_req",    2'b01, 2'b01, 32'h2000_0000, 32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("ae_both",   2'b01, 2'b01, 32'h2000_0000, 32'h0,         2'b10, 2'b10, 32'h0,         32'h5555_5555, 2'b10, 2'b10, 2'b00, 2'b01, 32'h5555_5555, 32'h0);
        add("ae_drop",   2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("idle3",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("unm_req",   2'b10, 2'b10, 32'h0,         32'h3000_0000, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("unm_pulse", 2'b10, 2'b10, 32'h0,         32'h3000_0000, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b10, 32'h0,         32'h0);
        add("unm_gap",   2'b10, 2'b10, 32'h0,         32'h3000_0000, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("unm_puls2", 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b10, 32'h0,         32'h0);
        add("idle4",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("lock_req",  2'b01, 2'b01, 32'h1000_0000, 32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("lock_hold", 2'b01, 2'b00, 32'h2000_0000, 32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b01, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("lock_drop", 2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);
        add("idle5",     2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0);

        // Reset state: requests present but reset held, every output stays low.
        cyc = 2'b11;
        stb = 2'b11;
        adr = {32'h1000_0010, 32'h1000_0000};
        tack = 2'b11;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_tcyc", 32'(tcyc), 32'h0);
        check("rst_tstb", 32'(tstb), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_dat_r0", dat_r[31:0], 32'h0);
        check("rst_tadr0", tadr[31:0], 32'h0);
        cyc = '0;
        stb = '0;
        tack = '0;
        reset_n = 1'b1;

        // Round robin on target 1: both request together.
        adr = {32'h2000_0200, 32'h2000_0100};
        step(2'b11, 2'b11, 2'b00);
        check("rr_arb_lat", 32'(tcyc), 32'h0);
        step(2'b11, 2'b11, 2'b10);
        check("rr_first_tcyc", 32'(tcyc), 32'h2);
        check("rr_first_tadr", tadr[63:32], 32'h2000_0100);
        check("rr_first_dat_w", tdat_w[63:32], 32'hA0A0_A0A0);
        check("rr_first_twe", 32'(twe), 32'h2);
        check("rr_first_ack", 32'(ack), 32'h1);
        step(2'b10, 2'b10, 2'b00);
        check("rr_owner_drop", 32'(tcyc), 32'h0);
        step(2'b10, 2'b10, 2'b00);
        check("rr_idle_gap", 32'(tcyc), 32'h0);
        step(2'b10, 2'b10, 2'b00);
        check("rr_second_tcyc", 32'(tcyc), 32'h2);
        check("rr_second_tadr", tadr[63:32], 32'h2000_0200);
        check("rr_second_dat_w", tdat_w[63:32], 32'hB1B1_B1B1);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        // Last winner was I1, so I0 wins the next contest.
        step(2'b11, 2'b11, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        check("rr_round2_tadr", tadr[63:32], 32'h2000_0100);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        // Last winner was I0, so I1 wins now.
        step(2'b11, 2'b11, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        check("rr_round3_tadr", tadr[63:32], 32'h2000_0200);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);

        foreach (vecs[k]) begin
            @(negedge clock);
            cyc    = vecs[k].cyc;
            stb    = vecs[k].stb;
            adr    = {vecs[k].adr1, vecs[k].adr0};
            tack   = vecs[k].tack;
            terr   = vecs[k].terr;
            tdat_r = {vecs[k].tdat1, vecs[k].tdat0};
            #1;
            check({vecs[k].name, "_tcyc"}, 32'(tcyc), 32'(vecs[k].e_tcyc));
            check({vecs[k].name, "_tstb"}, 32'(tstb), 32'(vecs[k].e_tstb));
            check({vecs[k].name, "_ack"}, 32'(ack), 32'(vecs[k].e_ack));
            check({vecs[k].name, "_err"}, 32'(err), 32'(vecs[k].e_err));
            check({vecs[k].name, "_dat_r0"}, dat_r[31:0], vecs[k].e_dat0);
            check({vecs[k].name, "_dat_r1"}, dat_r[63:32], vecs[k].e_dat1);
        end
        tdat_r = '0;
        terr   = '0;

        // Asynchronous reset while I0 owns target 0.
        adr = {32'h1000_0010, 32'h1000_0000};
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b01, 2'b01);
        check("ar_owned_tcyc", 32'(tcyc), 32'h1);
        check("ar_owned_ack", 32'(ack), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_tcyc_fall", 32'(tcyc), 32'h0);
        check("ar_tstb_fall", 32'(tstb), 32'h0);
        check("ar_ack_fall", 32'(ack), 32'h0);
        step(2'b11, 2'b11, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        reset_n = 1'b1;
        step(2'b11, 2'b11, 2'b00);
        check("ar_regrant_tcyc", 32'(tcyc), 32'h1);
        check("ar_regrant_tadr", tadr[31:0], 32'h1000_0000);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);

`ifdef WB_IC_TIMEOUT_EN
        // Target 0 never answers; watchdog fires on the 16th granted cycle.
        step(2'b01, 2'b01, 2'b00);
        for (int k = 0; k < 15; k++) begin
            step((k == 0) ? 2'b01 : 2'b11, (k == 0) ? 2'b01 : 2'b11, 2'b00);
            check($sformatf("to_wait%0d_tcyc", k), 32'(tcyc[0]), 32'h1);
            check($sformatf("to_wait%0d_err", k), 32'(err[0]), 32'h0);
        end
        step(2'b11, 2'b11, 2'b00);
        check("to_fire_err", 32'(err[0]), 32'h1);
        check("to_fire_tcyc", 32'(tcyc[0]), 32'h0);
        step(2'b10, 2'b10, 2'b00);
        check("to_idle_tcyc", 32'(tcyc[0]), 32'h0);
        check("to_idle_err", 32'(err[0]), 32'h0);
        step(2'b10, 2'b10, 2'b00);
        check("to_i1_tcyc", 32'(tcyc[0]), 32'h1);
        check("to_i1_tadr", tadr[31:0], 32'h1000_0010);
        step(2'b00, 2'b00, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
